// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - recovers two 2-digit decimal values from a scanned 7-segment bus
module seg_scan_decoder #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 250_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg_in,
    input  logic [3:0] sel_in,
    output logic [7:0] dat1,
    output logic [7:0] dat2,
    output logic       valid,
    output logic       err,
    output logic       locked
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SETTLING,
        ST_HOLD
    } state_t;

    state_t        state, state_nx;
    logic [SW-1:0] scnt, scnt_nx;
    logic [TW-1:0] tcnt;
    logic [7:0]    seg_r, seg_d;
    logic [3:0]    sel_r, sel_d;
    logic [3:0]    mask;
    logic          bad;
    logic [3:0]    digits [4];

    logic          sel_ok;
    logic [1:0]    slot;
    logic [3:0]    digit;
    logic          inv;
    logic          sample;
    logic          changed;
    logic          complete;
    logic          timeout;

    // Map the registered select code onto a slot index; anything not one-hot-low is illegal
    always_comb begin
        sel_ok = 1'b1;
        slot   = 2'd0;
        case (sel_r)
            4'b1110: slot = 2'd0;
            4'b1101: slot = 2'd1;
            4'b1011: slot = 2'd2;
            4'b0111: slot = 2'd3;
            default: sel_ok = 1'b0;
        endcase
    end

    // Decode the registered segment pattern (dp included) into a decimal digit
    always_comb begin
        inv   = 1'b0;
        digit = 4'd0;
        case (seg_r)
            8'hc0:   digit = 4'd0;
            8'hf9:   digit = 4'd1;
            8'ha4:   digit = 4'd2;
            8'hb0:   digit = 4'd3;
            8'h99:   digit = 4'd4;
            8'h92:   digit = 4'd5;
            8'h82:   digit = 4'd6;
            8'hf8:   digit = 4'd7;
            8'h80:   digit = 4'd8;
            8'h90:   digit = 4'd9;
            default: inv   = 1'b1;
        endcase
    end

    assign changed  = (sel_r != sel_d) || (seg_r != seg_d);
    assign complete = (mask == 4'b1111);
    assign timeout  = !complete && (tcnt == TW'(TIMEOUT - 1));

    // Settle/sample FSM: next state, settle count and the sample strobe
    always_comb begin
        state_nx = state;
        scnt_nx  = scnt;
        sample   = 1'b0;
        case (state)
            ST_WAIT: begin
                if (sel_ok) begin
                    state_nx = ST_SETTLING;
                    scnt_nx  = SW'(1);
                end
            end
            ST_SETTLING: begin
                if (!sel_ok) begin
                    state_nx = ST_WAIT;
                    scnt_nx  = '0;
                end else if (changed) begin
                    scnt_nx = SW'(1);
                end else if (scnt + SW'(1) == SW'(SETTLE)) begin
                    sample   = 1'b1;
                    state_nx = ST_HOLD;
                    scnt_nx  = SW'(SETTLE);
                end else begin
                    scnt_nx = scnt + SW'(1);
                end
            end
            ST_HOLD: begin
                // Segment-only changes are ignored: the driver may repaint while selected
                if (sel_r != sel_d) begin
                    if (sel_ok) begin
                        state_nx = ST_SETTLING;
                        scnt_nx  = SW'(1);
                    end else begin
                        state_nx = ST_WAIT;
                        scnt_nx  = '0;
                    end
                end
            end
            default: begin
                state_nx = ST_WAIT;
                scnt_nx  = '0;
            end
        endcase
    end

    // Input registers, FSM state, slot capture, frame conversion and timeout handling
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r  <= 8'hff;
            sel_r  <= 4'hf;
            seg_d  <= 8'hff;
            sel_d  <= 4'hf;
            state  <= ST_WAIT;
            scnt   <= '0;
            tcnt   <= '0;
            mask   <= 4'b0000;
            bad    <= 1'b0;
            dat1   <= 8'd0;
            dat2   <= 8'd0;
            valid  <= 1'b0;
            err    <= 1'b0;
            locked <= 1'b0;
            for (int i = 0; i < 4; i++) digits[i] <= 4'd0;
        end else begin
            seg_r <= seg_in;
            sel_r <= sel_in;
            seg_d <= seg_r;
            sel_d <= sel_r;
            valid <= 1'b0;
            err   <= 1'b0;
            if (sample && !timeout) digits[slot] <= digit;
            if (complete) begin
                // Convert stage wins over a coincident timeout
                tcnt  <= '0;
                state <= state_nx;
                scnt  <= scnt_nx;
                mask  <= sample ? (4'b0001 << slot) : 4'b0000;
                bad   <= sample & inv;
                if (!bad) begin
                    dat1   <= ({4'd0, digits[0]} << 3) + ({4'd0, digits[0]} << 1) + {4'd0, digits[1]};
                    dat2   <= ({4'd0, digits[2]} << 3) + ({4'd0, digits[2]} << 1) + {4'd0, digits[3]};
                    valid  <= 1'b1;
                    locked <= 1'b1;
                end else begin
                    err    <= 1'b1;
                    locked <= 1'b0;
                end
            end else if (timeout) begin
                tcnt   <= '0;
                state  <= ST_WAIT;
                scnt   <= '0;
                mask   <= 4'b0000;
                bad    <= 1'b0;
                err    <= 1'b1;
                locked <= 1'b0;
            end else begin
                tcnt  <= tcnt + TW'(1);
                state <= state_nx;
                scnt  <= scnt_nx;
                if (sample) begin
                    mask[slot] <= 1'b1;
                    bad        <= bad | inv;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - randomized self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 2000;
    localparam int DWELL   = 50;
    localparam int LAG     = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] seg_in;
    logic [3:0] sel_in;
    logic [7:0] dat1, dat2;
    logic       valid, err, locked;

    seg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .rst    (rst),
        .seg_in (seg_in),
        .sel_in (sel_in),
        .dat1   (dat1),
        .dat2   (dat2),
        .valid  (valid),
        .err    (err),
        .locked (locked)
    );

    always #5 clk = ~clk;

    logic [7:0] seg_tab [10] = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8, 8'h80, 8'h90};
    logic [3:0] sel_tab [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    int n_checks = 0;
    int n_errors = 0;
    int cur_v1 = 0, cur_v2 = 0;
    int n_valid = 0, n_err = 0;
    int cyc = 0;
    int last_valid_cyc = 0, err_cyc_prev = 0, err_cyc_last = 0;
    logic [7:0] last_seg = 8'hff;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Every valid must carry the values currently on display and never coincide with err
    always @(negedge clk) begin
        cyc++;
        if (valid) begin
            n_valid++;
            last_valid_cyc = cyc;
            chk("valid_dat1", dat1, cur_v1);
            chk("valid_dat2", dat2, cur_v2);
            chk("valid_err_excl", err, 0);
        end
        if (err) begin
            n_err++;
            err_cyc_prev = err_cyc_last;
            err_cyc_last = cyc;
        end
    end

    function automatic logic [7:0] slot_seg(input int s);
        int v;
        v = (s < 2) ? cur_v1 : cur_v2;
        return seg_tab[(s % 2 == 0) ? v / 10 : v % 10];
    endfunction

    task automatic tick(input logic [3:0] s, input logic [7:0] g);
        @(posedge clk);
        #1;
        sel_in = s;
        seg_in = g;
    endtask

    // Scan driver model: select moves first, segments follow LAG cycles later
    task automatic dwell(input int slot, input logic [7:0] g, input int n);
        for (int c = 0; c < n; c++) tick(sel_tab[slot], (c < LAG) ? last_seg : g);
        if (n > LAG) last_seg = g;
    endtask

    task automatic frame(input int v1, input int v2, input int bad_slot);
        cur_v1 = v1;
        cur_v2 = v2;
        for (int s = 0; s < 4; s++) dwell(s, (s == bad_slot) ? 8'hff : slot_seg(s), DWELL);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_dat1"}, dat1, 0);
        chk({tag, "_dat2"}, dat2, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_locked"}, locked, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base_v, base_e, v1, v2;
        rst    = 1'b1;
        sel_in = 4'hf;
        seg_in = 8'hff;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        // Basic display 42/07
        base_v = n_valid;
        frame(42, 7, -1);
        frame(42, 7, -1);
        chk("basic_valid_count", n_valid - base_v, 2);
        chk("basic_dat1", dat1, 42);
        chk("basic_dat2", dat2, 7);
        chk("basic_locked", locked, 1);
        chk("basic_no_err", n_err, 0);

        // Random values
        repeat (6) begin
            v1 = $urandom_range(0, 99);
            v2 = $urandom_range(0, 99);
            base_v = n_valid;
            frame(v1, v2, -1);
            frame(v1, v2, -1);
            chk("rand_valid_count", n_valid - base_v, 2);
            chk("rand_dat1", dat1, v1);
            chk("rand_dat2", dat2, v2);
            chk("rand_locked", locked, 1);
        end

        // Extremes
        frame(99, 0, -1);
        frame(99, 0, -1);
        chk("ext_a_dat1", dat1, 99);
        chk("ext_a_dat2", dat2, 0);
        frame(0, 99, -1);
        frame(0, 99, -1);
        chk("ext_b_dat1", dat1, 0);
        chk("ext_b_dat2", dat2, 99);
        chk("ext_no_err", n_err, 0);

        // Blank slot2 for one frame
        frame(42, 7, -1);
        base_v = n_valid;
        base_e = n_err;
        frame(42, 7, 2);
        chk("bad_no_valid", n_valid - base_v, 0);
        chk("bad_err_count", n_err - base_e, 1);
        chk("bad_dat1_hold", dat1, 42);
        chk("bad_dat2_hold", dat2, 7);
        chk("bad_locked", locked, 0);
        base_v = n_valid;
        frame(42, 7, -1);
        chk("recover_valid", n_valid - base_v, 1);
        chk("recover_locked", locked, 1);

        // Short slot1 glitch must not count as a capture
        base_v = n_valid;
        dwell(0, slot_seg(0), DWELL);
        dwell(1, slot_seg(1), 2);
        dwell(0, slot_seg(0), DWELL);
        dwell(2, slot_seg(2), DWELL);
        dwell(3, slot_seg(3), DWELL);
        chk("glitch_no_valid", n_valid - base_v, 0);
        dwell(1, slot_seg(1), DWELL);
        chk("glitch_then_valid", n_valid - base_v, 1);
        chk("glitch_locked", locked, 1);

        // Reset after three captured slots
        cur_v1 = 13;
        cur_v2 = 58;
        base_v = n_valid;
        dwell(0, slot_seg(0), DWELL);
        dwell(1, slot_seg(1), DWELL);
        dwell(2, slot_seg(2), DWELL);
        chk("pre_reset_no_valid", n_valid - base_v, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("midreset");
        rst = 1'b0;
        dwell(3, slot_seg(3), DWELL);
        dwell(0, slot_seg(0), DWELL);
        dwell(1, slot_seg(1), DWELL);
        chk("post_reset_partial", n_valid - base_v, 0);
        dwell(2, slot_seg(2), DWELL);
        chk("post_reset_valid", n_valid - base_v, 1);
        chk("post_reset_dat1", dat1, 13);
        chk("post_reset_dat2", dat2, 58);

        // Hold one select: periodic timeout after the last completion
        base_v = n_valid;
        base_e = n_err;
        for (int i = 0; i < 2 * TIMEOUT + 200 && n_err < base_e + 2; i++)
            tick(sel_tab[0], slot_seg(0));
        chk("timeout_err_count", n_err - base_e, 2);
        chk("timeout_first_gap", err_cyc_prev - last_valid_cyc, TIMEOUT);
        chk("timeout_repeat_gap", err_cyc_last - err_cyc_prev, TIMEOUT);
        chk("timeout_no_valid", n_valid - base_v, 0);
        chk("timeout_locked", locked, 0);
        chk("timeout_dat1_hold", dat1, 13);
        chk("timeout_dat2_hold", dat2, 58);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the team's 4-digit multiplexed 7-segment scan driver: watches the active-low segment bus and the active-low digit-select bus, and recovers the two displayed 2-digit decimal values as binary.
- Used for on-chip loopback self-check of the display path and for capturing display contents from an external scanned panel.
- Only input is the scan bus; it produces a per-frame valid pulse, error flag and lock status.

Parameters:
- SETTLE, 4, consecutive cycles sel_in and seg_in must both be unchanged before a digit is sampled; must be >= 3 to cover the driver's 2-cycle select-to-segment lag.
- TIMEOUT, 250_000, cycles allowed without a completed frame before err/loss of lock (about 5 scan periods of 50_000 cycles).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- seg_in  input  8  segment bus, active-low, bit7 = dp
- sel_in  input  4  digit select, active-low one-hot
- dat1  output  8  binary value from digits sel 1110 (tens) and 1101 (ones), 0..99
- dat2  output  8  binary value from digits sel 1011 (tens) and 0111 (ones), 0..99
- valid  output  1  1-cycle pulse when dat1/dat2 update
- err  output  1  1-cycle pulse on bad frame or timeout
- locked  output  1  high after a good frame; low after reset, timeout or bad frame
- Interface decision: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Reset (rst=1 at clk edge): dat1=0, dat2=0, valid=0, err=0, locked=0, capture mask=0000, bad flag=0, settle and timeout counters=0, FSM=WAIT.
- Inputs are registered once (seg_r, sel_r); all decisions use the registered copies.
- Legal sel_r codes: 1110=slot0, 1101=slot1, 1011=slot2, 0111=slot3. Any other code (0000, 1111, multi-low) forces WAIT and clears the settle counter; mask is kept.
- Segment decode of seg_r:
  - c0=0, f9=1, a4=2, b0=3, 99=4, 92=5, 82=6, f8=7, 80=8, 90=9.
  - Anything else (including ff) decodes as invalid.
- FSM:
  - WAIT: on a legal sel_r go to SETTLING with settle cnt=1.
  - SETTLING: if sel_r or seg_r differs from the previous cycle, reset cnt=1 (illegal sel -> WAIT). Otherwise increment. When cnt reaches SETTLE, sample: store digit in slot, set mask bit, OR invalid into bad flag, go to HOLD.
  - HOLD: stay until sel_r changes. Legal new code -> SETTLING (cnt=1); illegal -> WAIT. Changes of seg_r alone are ignored.
  - Re-sampling a slot already in the mask overwrites it (latest wins). Slot order is irrelevant.
- Frame completion: the cycle after mask becomes 1111 (convert stage), clear mask and bad flag, and clear the timeout counter.
  - Good frame (bad=0): dat1 = tens0*10 + ones1, dat2 = tens2*10 + ones3, computed as (t<<3)+(t<<1)+o in 8 bits. valid=1 for one cycle, locked=1.
  - Bad frame (bad=1): dat1/dat2 hold, valid=0, err=1 for one cycle, locked=0.
  - Latency: final sample at edge N; dat/valid/err at edge N+1.
- Timeout counter:
  - Increments every cycle that is not a frame completion.
  - At TIMEOUT-1: err pulse, locked=0, mask and bad flag cleared, counter to 0, FSM to WAIT. dat1/dat2 hold.
  - If a frame completes in the same cycle as timeout, the completion wins and the timeout is ignored.
- valid and err are never high in the same cycle.
- Reset mid-frame discards partial captures; the first valid follows a full fresh frame.

Test Plan:
- Driver model (dwell 50 cycles, 2-cycle seg lag) shows 42/07 -> within 2 frames valid pulses once per frame; dat1=42, dat2=7, locked=1, err=0.
- Extremes 99/00, then 00/99 -> dat1=99, dat2=0, then dat1=0, dat2=99. Each update coincides with valid, no intermediate mixed values.
- Force seg_in=ff during the slot2 dwell for one frame -> err pulse, valid=0, dat unchanged (42/7), locked=0. The next clean frame restores valid and locked=1.
- Glitch: sel_in=1101 for 2 cycles then back to 1110 with SETTLE=4 -> no slot1 capture, no valid until a full-length slot1 dwell occurs.
- Hold sel_in=1110 constant -> err pulse exactly TIMEOUT cycles after the last completion, locked=0, dat held. Repeats every TIMEOUT cycles.
- Assert rst after 3 of 4 slots captured, then release -> all outputs 0. Valid only after all 4 slots are re-captured.
